cassette_rec: RTL and testbench

//  Cassette recorder: writer side of the tape path whose reader plays SDRAM bytes out as casdout.

---
 rtl/cassette_rec_if.sv | 20 ++
 rtl/cassette_rec.sv | 208 ++++++++++++++++++++
 tb/tb_cassette_rec.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cassette_rec_if.sv
// Cassette recorder SDRAM write port.
// Byte address, byte data, write request held until a one-cycle ack.
interface cassette_rec_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_data;
  logic              sdram_we;
  logic              sdram_ack;

  modport master (
    output sdram_addr, sdram_data, sdram_we,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr, sdram_data, sdram_we,
    output sdram_ack
  );
endinterface

// File: rtl/cassette_rec.sv
// Cassette recorder: DAC crossings -> FSK bits -> bytes -> SDRAM.
// Optional CASREC_LEADER_SYNC_EN: hunt for 8'h55 before framing bytes.
module cassette_rec #(
  parameter int SPLIT_CYC  = 35795,
  parameter int MIN_CYC    = 11454,
  parameter int MAX_CYC    = 71590,
  parameter int HYST       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              motor,
  input  logic [5:0]        dac,
  cassette_rec_if.master    sdram,
  output logic [ADDR_W-1:0] byte_count,
  output logic              recording,
  output logic              overflow
);

  localparam int CW  = $clog2(MAX_CYC + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = ADDR_W + 1;

  localparam logic [CW-1:0] C_MIN   = CW'(MIN_CYC);
  localparam logic [CW-1:0] C_SPLIT = CW'(SPLIT_CYC);
  localparam logic [CW-1:0] C_MAX   = CW'(MAX_CYC);
  localparam logic [5:0]    LVL_HI  = 6'(32 + HYST);
  localparam logic [5:0]    LVL_LO  = 6'(31 - HYST);
  localparam logic [PW:0]   FULL    = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {W_IDLE, W_REQ} wstate_t;

  logic           cmp, cmp_q, record_q;
  logic           rise, arm, gap;
  logic           bit_ok, bit_val;
  logic           push_req, push_ok;
  logic           full, room;
  logic [CW-1:0]  cnt;
  logic [7:0]     shreg, sh_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [PW:0]    fill;
  logic [AW1-1:0] addr_q, next_slot;
  logic [7:0]     data_q;
  logic           pop, done;
  wstate_t        state, state_nx;
`ifdef CASREC_LEADER_SYNC_EN
  logic           synced;
`endif

  assign rise    = recording & cmp & ~cmp_q;
  assign arm     = record & ~record_q;
  assign gap     = rise && (cnt >= C_MAX);
  assign bit_ok  = rise && (cnt >= C_MIN)
                   && (cnt < C_MAX);
  assign bit_val = (cnt < C_SPLIT);
  assign sh_next = {bit_val, shreg[7:1]};

`ifdef CASREC_LEADER_SYNC_EN
  assign push_req = bit_ok && (synced
                    ? (bit_cnt == 3'd7)
                    : (sh_next == 8'h55));
`else
  assign push_req = bit_ok && (bit_cnt == 3'd7);
`endif

  // Next address that a newly pushed byte would land on.
  assign next_slot = addr_q + AW1'(fill)
                     + AW1'(state == W_REQ);
  assign full    = (fill == FULL);
  assign room    = ~next_slot[ADDR_W];
  assign push_ok = push_req & ~full & room;

  // Hysteresis comparator and registered control levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp       <= 1'b0;
      cmp_q     <= 1'b0;
      record_q  <= 1'b0;
      recording <= 1'b0;
    end else begin
      cmp_q <= cmp;
      if (dac >= LVL_HI)
        cmp <= 1'b1;
      else if (dac <= LVL_LO)
        cmp <= 1'b0;
      record_q  <= record;
      recording <= record & motor;
    end
  end

  // Period measurement and bit packing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef CASREC_LEADER_SYNC_EN
      synced  <= 1'b0;
`endif
    end else if (!recording) begin
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef CASREC_LEADER_SYNC_EN
      synced  <= 1'b0;
`endif
    end else if (gap) begin
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef CASREC_LEADER_SYNC_EN
      synced  <= 1'b0;
`endif
    end else if (bit_ok) begin
      cnt   <= '0;
      shreg <= sh_next;
`ifdef CASREC_LEADER_SYNC_EN
      if (synced)
        bit_cnt <= bit_cnt + 3'd1;
      else if (sh_next == 8'h55)
        synced <= 1'b1;
`else
      bit_cnt <= bit_cnt + 3'd1;
`endif
    end else if (cnt != C_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Byte FIFO between the bit packer and the writer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= sh_next;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   fill <= fill + (PW+1)'(1);
        2'b01:   fill <= fill - (PW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Writer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= W_IDLE;
    else
      state <= state_nx;
  end

  // Writer next state: load head on entry, retire on ack.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done     = 1'b0;
    unique case (state)
      W_IDLE: if (fill != '0) begin
        state_nx = W_REQ;
        pop      = 1'b1;
      end
      W_REQ: if (sdram.sdram_ack) begin
        state_nx = W_IDLE;
        done     = 1'b1;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  // Write data, tape address and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      addr_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)
        data_q <= mem[rd_ptr];
      if (arm)
        addr_q <= '0;
      else if (done)
        addr_q <= addr_q + AW1'(1);
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (arm)
        overflow <= 1'b0;
    end
  end

  assign sdram.sdram_addr = addr_q[ADDR_W-1:0];
  assign sdram.sdram_data = data_q;
  assign sdram.sdram_we   = (state == W_REQ);
  assign byte_count       = addr_q[ADDR_W-1:0];

endmodule

// File: tb/tb_cassette_rec.sv
// Directed bench for cassette_rec with short timing parameters.
// Emulates the SDRAM ack and logs every accepted write.
module tb_cassette_rec;

  localparam logic [5:0] HI = 6'd50;
  localparam logic [5:0] LO = 6'd10;

  logic        clk;
  logic        rst_n;
  logic        record;
  logic        motor;
  logic [5:0]  dac;
  logic [24:0] byte_count;
  logic        recording;
  logic        overflow;
  logic        ack_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic [24:0] wq_addr[$];
  logic [7:0]  wq_data[$];

  cassette_rec_if #(.ADDR_W(25)) bus ();

  cassette_rec #(
    .SPLIT_CYC(100),
    .MIN_CYC(20),
    .MAX_CYC(400),
    .HYST(4),
    .FIFO_DEPTH(4),
    .ADDR_W(25)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .record    (record),
    .motor     (motor),
    .dac       (dac),
    .sdram     (bus),
    .byte_count(byte_count),
    .recording (recording),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    bus.sdram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.sdram_ack) begin
        bus.sdram_ack = 1'b0;
      end else if (bus.sdram_we && ack_en) begin
        wq_addr.push_back(bus.sdram_addr);
        wq_data.push_back(bus.sdram_data);
        bus.sdram_ack = 1'b1;
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_period(input int p);
    hold(p / 2);
    dac = LO;
    hold(p - p / 2);
    dac = HI;
  endtask

  task automatic bit_glitch();
    hold(5);
    dac = LO;
    hold(10);
    dac = HI;
    hold(15);
    dac = LO;
    hold(30);
    dac = HI;
  endtask

  task automatic start_rise();
    dac = LO;
    hold(500);
    dac = HI;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      bit_period(b[i] ? 60 : 140);
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 400 && wq_data.size() < n; k++)
      @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    record = 1'b0;
    motor  = 1'b0;
    dac    = LO;
    ack_en = 1'b1;
    hold(5);
    n_tests++;
    if (bus.sdram_we !== 1'b0) begin
      $display("FAIL rst_we got %b want 0", bus.sdram_we);
      n_fail++;
    end
    n_tests++;
    if (bus.sdram_addr !== 25'd0) begin
      $display("FAIL rst_addr got %h want 0", bus.sdram_addr);
      n_fail++;
    end
    n_tests++;
    if (bus.sdram_data !== 8'd0) begin
      $display("FAIL rst_data got %h want 0", bus.sdram_data);
      n_fail++;
    end
    n_tests++;
    if (byte_count !== 25'd0) begin
      $display("FAIL rst_bc got %h want 0", byte_count);
      n_fail++;
    end
    n_tests++;
    if (recording !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL rst_flags got %b%b want 00",
               recording, overflow);
      n_fail++;
    end
    rst_n = 1'b1;
    hold(2);
  endtask

  task automatic test_basic();
    logic [7:0] b;
    b = 8'hA5;
    record = 1'b1;
    motor  = 1'b1;
    hold(3);
    n_tests++;
    if (recording !== 1'b1) begin
      $display("FAIL recording got %b want 1", recording);
      n_fail++;
    end
    start_rise();
    for (int i = 0; i < 8; i++) begin
      if (i == 2)
        bit_glitch();
      else
        bit_period(b[i] ? 60 : 140);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.sdram_we !== 1'b0) begin
      $display("FAIL lat_n0 we got %b want 0", bus.sdram_we);
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.sdram_we !== 1'b0) begin
      $display("FAIL lat_n1 we got %b want 0", bus.sdram_we);
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.sdram_we !== 1'b1) begin
      $display("FAIL lat_n2 we got %b want 1", bus.sdram_we);
      n_fail++;
    end
    wait_writes(1);
    hold(2);
    n_tests++;
    if (wq_data.size() != 1 || wq_data[0] !== 8'hA5
        || wq_addr[0] !== 25'd0) begin
      $display("FAIL basic_wr n=%0d data %h addr %h want 1 A5 0",
               wq_data.size(), wq_data[0], wq_addr[0]);
      n_fail++;
    end
    n_tests++;
    if (byte_count !== 25'd1) begin
      $display("FAIL basic_bc got %0d want 1", byte_count);
      n_fail++;
    end
  endtask

  task automatic test_gap();
    wq_data.delete();
    wq_addr.delete();
    bit_period(60);
    bit_period(140);
    bit_period(60);
    bit_period(500);
    send_byte(8'h3C);
    wait_writes(1);
    hold(2);
    n_tests++;
    if (wq_data.size() != 1 || wq_data[0] !== 8'h3C
        || wq_addr[0] !== 25'd1) begin
      $display("FAIL gap_wr n=%0d data %h addr %h want 1 3C 1",
               wq_data.size(), wq_data[0], wq_addr[0]);
      n_fail++;
    end
    n_tests++;
    if (byte_count !== 25'd2) begin
      $display("FAIL gap_bc got %0d want 2", byte_count);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    wq_data.delete();
    wq_addr.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = 8'(8'h11 * (i + 1));
      send_byte(v);
    end
    hold(5);
    n_tests++;
    if (bus.sdram_we !== 1'b1 || bus.sdram_data !== 8'h11) begin
      $display("FAIL ovf_hold we %b data %h want 1 11",
               bus.sdram_we, bus.sdram_data);
      n_fail++;
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_flag got %b want 1", overflow);
      n_fail++;
    end
    n_tests++;
    if (byte_count !== 25'd2) begin
      $display("FAIL ovf_bc_hold got %0d want 2", byte_count);
      n_fail++;
    end
    ack_en = 1'b1;
    wait_writes(5);
    hold(6);
    n_tests++;
    if (wq_data.size() != 5) begin
      $display("FAIL ovf_count got %0d want 5", wq_data.size());
      n_fail++;
    end
    for (int i = 0; i < 5 && i < wq_data.size(); i++) begin
      v = 8'(8'h11 * (i + 1));
      n_tests++;
      if (wq_data[i] !== v || wq_addr[i] !== 25'(2 + i)) begin
        $display("FAIL ovf_wr%0d data %h addr %0d want %h %0d",
                 i, wq_data[i], wq_addr[i], v, 2 + i);
        n_fail++;
      end
    end
    n_tests++;
    if (byte_count !== 25'd7 || bus.sdram_we !== 1'b0) begin
      $display("FAIL ovf_drain bc %0d we %b want 7 0",
               byte_count, bus.sdram_we);
      n_fail++;
    end
  endtask

  task automatic test_pause();
    wq_data.delete();
    wq_addr.delete();
    motor = 1'b0;
    dac   = LO;
    hold(3);
    n_tests++;
    if (recording !== 1'b0) begin
      $display("FAIL pause_rec got %b want 0", recording);
      n_fail++;
    end
    hold(997);
    motor = 1'b1;
    start_rise();
    send_byte(8'h77);
    wait_writes(1);
    hold(2);
    n_tests++;
    if (wq_data.size() != 1 || wq_data[0] !== 8'h77
        || wq_addr[0] !== 25'd7) begin
      $display("FAIL pause_wr n=%0d data %h addr %0d want 1 77 7",
               wq_data.size(), wq_data[0], wq_addr[0]);
      n_fail++;
    end
    n_tests++;
    if (byte_count !== 25'd8 || overflow !== 1'b1) begin
      $display("FAIL pause_bc bc %0d ovf %b want 8 1",
               byte_count, overflow);
      n_fail++;
    end
    record = 1'b0;
    hold(10);
    record = 1'b1;
    hold(3);
    n_tests++;
    if (byte_count !== 25'd0 || bus.sdram_addr !== 25'd0
        || overflow !== 1'b0) begin
      $display("FAIL rearm bc %0d addr %0d ovf %b want 0 0 0",
               byte_count, bus.sdram_addr, overflow);
      n_fail++;
    end
  endtask

  task automatic test_reset_midwrite();
    wq_data.delete();
    wq_addr.delete();
    ack_en = 1'b0;
    start_rise();
    send_byte(8'h5A);
    for (int k = 0; k < 10 && bus.sdram_we !== 1'b1; k++)
      hold(1);
    n_tests++;
    if (bus.sdram_we !== 1'b1 || bus.sdram_data !== 8'h5A) begin
      $display("FAIL mid_pre we %b data %h want 1 5A",
               bus.sdram_we, bus.sdram_data);
      n_fail++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.sdram_we !== 1'b0 || bus.sdram_data !== 8'h00) begin
      $display("FAIL mid_rst we %b data %h want 0 00",
               bus.sdram_we, bus.sdram_data);
      n_fail++;
    end
    n_tests++;
    if (recording !== 1'b0 || byte_count !== 25'd0
        || bus.sdram_addr !== 25'd0 || overflow !== 1'b0) begin
      $display("FAIL mid_rst_out rec %b bc %0d addr %0d ovf %b want 0",
               recording, byte_count, bus.sdram_addr, overflow);
      n_fail++;
    end
    dac = LO;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(2);
    ack_en = 1'b1;
  endtask

  task automatic test_leader_sync();
    logic [7:0] exp [3];
`ifdef CASREC_LEADER_SYNC_EN
    exp[0] = 8'h55;
    exp[1] = 8'h55;
    exp[2] = 8'h3C;
`else
    exp[0] = 8'hAC;
    exp[1] = 8'hAA;
    exp[2] = 8'hE2;
`endif
    wq_data.delete();
    wq_addr.delete();
    start_rise();
    bit_period(140);
    bit_period(140);
    bit_period(60);
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'h3C);
    wait_writes(3);
    hold(4);
    n_tests++;
    if (wq_data.size() != 3) begin
      $display("FAIL sync_count got %0d want 3", wq_data.size());
      n_fail++;
    end
    for (int i = 0; i < 3 && i < wq_data.size(); i++) begin
      n_tests++;
      if (wq_data[i] !== exp[i] || wq_addr[i] !== 25'(i)) begin
        $display("FAIL sync_wr%0d data %h addr %0d want %h %0d",
                 i, wq_data[i], wq_addr[i], exp[i], i);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_pause();
    test_reset_midwrite();
    test_leader_sync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
